// File: rtl/pwm_capture.sv
// PWM/pulse-train capture: measures high time and rising-to-rising period in clk cycles,
// publishes one result per input period and flags a stuck input with a timeout strobe.
module pwm_capture #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pwm_in,
    output logic [BITS-1:0] high_count,
    output logic [BITS-1:0] period_count,
    output logic            valid,
    output logic            timeout,
    output logic            level
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_e;

    localparam logic [BITS-1:0] CNT_MAX = '1;
    localparam logic [BITS-1:0] CNT_ONE = BITS'(1);

    state_e          state_q, state_d;
    logic            s1_q, s2_q, prev_q;
    logic [BITS-1:0] cnt_q, cnt_d;
    logic [BITS-1:0] hi_q, hi_d;
    logic [BITS-1:0] high_q, high_d;
    logic [BITS-1:0] period_q, period_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic            rise, fall;

    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

    // NOTE: the two-flop synchronizer is reset like every other flop so that an input
    // already high at reset release is seen as a rise (prev=0) and handled as a partial period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= pwm_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        high_d    = high_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH: begin
                // Saturate rather than wrap; a late edge after all-ones is caught as a timeout.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                if (fall) begin
                    state_d = LOW;
                    hi_d    = cnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    high_d    = CNT_MAX;
                    period_d  = '0;
                end
            end
            LOW: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                if (rise) begin
                    state_d  = HIGH;
                    cnt_d    = CNT_ONE;
                    high_d   = hi_q;
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    high_d    = '0;
                    period_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            high_q    <= high_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign high_count   = high_q;
    assign period_count = period_q;
    assign valid        = valid_q;
    assign timeout      = timeout_q;
    assign level        = s2_q;

endmodule
